decay_timestep_scheduler: RTL and testbench

- Sweeps every neuron's membrane potential once per timestep and applies the LIF decay.
- Reads the potential and the per-neuron decay-rate code from the neuron-state memory, then computes the decayed IEEE-754 single value by exponent adjustment.
- The 1/2+1/4 case uses the shared Addition_Subtraction adder through a handshake. The result is written back to the same address.
- Sits between the timestep controller (start/done) and the neuron-state memory. It replaces the free-running, clear-triggered decay path.

---
 rtl/neuron_pkg.sv | 38 +++
 rtl/fp_exp_shift.sv | 28 ++
 rtl/decay_timestep_scheduler.sv | 172 +++++++++++++++++
 tb/tb_decay_timestep_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron-state decay path: decay-rate codes,
// IEEE-754 single field positions and the sweep scheduler state encoding.
package neuron_pkg;

  localparam logic [3:0] DECAY_DIV1         = 4'b0001;
  localparam logic [3:0] DECAY_DIV2         = 4'b0010;
  localparam logic [3:0] DECAY_DIV4         = 4'b0100;
  localparam logic [3:0] DECAY_DIV8         = 4'b1000;
  localparam logic [3:0] DECAY_HALF_QUARTER = 4'b0011;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_ADD,
    ST_ADDW,
    ST_WR,
    ST_DONE
  } sched_state_t;

  // Exponent decrement for the single-shift codes; zero means "leave untouched".
  function automatic logic [1:0] decay_shift(input logic [3:0] rate);
    case (rate)
      DECAY_DIV1: decay_shift = 2'd0;
      DECAY_DIV2: decay_shift = 2'd1;
      DECAY_DIV4: decay_shift = 2'd2;
      DECAY_DIV8: decay_shift = 2'd3;
      default:    decay_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fp_exp_shift.sv
// Divides an IEEE-754 single by 2^k through the exponent field alone.
// Inf/NaN and k=0 pass through; results that would leave the normal range flush to signed zero.
module fp_exp_shift
  import neuron_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  k,
  output logic [31:0] shifted
);

  logic [7:0] w_exp;
  logic [7:0] w_k;

  assign w_exp = value[EXP_HI:EXP_LO];
  assign w_k   = {6'd0, k};

  always_comb begin
    shifted = value;
    if (w_exp != EXP_SPECIAL && k != 2'd0) begin
      if (w_exp > w_k) begin
        shifted = {value[SIGN_BIT], w_exp - w_k, value[EXP_LO-1:0]};
      end else begin
        shifted = {value[SIGN_BIT], 31'd0};
      end
    end
  end

endmodule

// File: rtl/decay_timestep_scheduler.sv
// Once per timestep, walks every neuron, applies the LIF decay to its membrane
// potential and writes the result back; the 1/2+1/4 code borrows the shared adder.
module decay_timestep_scheduler
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 1024,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timestep_start,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              add_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_potential,
  input  logic [3:0]        mem_rd_rate,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              add_valid,
  input  logic              add_ready,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic              add_done,
  input  logic [31:0]       add_result,
  input  logic              add_exception
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_NEURONS - 1);

  sched_state_t      r_state;
  sched_state_t      w_nextState;
  logic [ADDR_W-1:0] r_index;
  logic [31:0]       r_potential;
  logic [31:0]       r_result;
  logic [31:0]       r_addA;
  logic [31:0]       r_addB;
  logic              r_overrun;
  logic              r_addErr;

  logic [1:0]        w_directK;
  logic [31:0]       w_direct;
  logic [31:0]       w_halfVal;
  logic [31:0]       w_quarterVal;
  logic              w_special;

  assign w_directK = decay_shift(mem_rd_rate);
  assign w_special = (mem_rd_potential[EXP_HI:EXP_LO] == EXP_SPECIAL);

  fp_exp_shift u_direct (
    .value   (mem_rd_potential),
    .k       (w_directK),
    .shifted (w_direct)
  );

  fp_exp_shift u_half (
    .value   (mem_rd_potential),
    .k       (2'd1),
    .shifted (w_halfVal)
  );

  fp_exp_shift u_quarter (
    .value   (mem_rd_potential),
    .k       (2'd2),
    .shifted (w_quarterVal)
  );

  assign overrun = r_overrun;
  assign add_err = r_addErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Memory and adder strobes are decoded from the state so that reset or IDLE forces every output low.
  always_comb begin
    w_nextState = r_state;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    add_valid   = 1'b0;
    add_a       = '0;
    add_b       = '0;
    case (r_state)
      ST_IDLE: begin
        if (timestep_start) w_nextState = ST_RD;
      end
      ST_RD: begin
        mem_rd_en   = 1'b1;
        mem_addr    = r_index;
        w_nextState = ST_CALC;
      end
      ST_CALC: begin
        if (!w_special && mem_rd_rate == DECAY_HALF_QUARTER) begin
          w_nextState = ST_ADD;
        end else begin
          w_nextState = ST_WR;
        end
      end
      ST_ADD: begin
        add_valid = 1'b1;
        add_a     = r_addA;
        add_b     = r_addB;
        if (add_ready) w_nextState = ST_ADDW;
      end
      ST_ADDW: begin
        if (add_done) w_nextState = ST_WR;
      end
      ST_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = r_index;
        mem_wr_data = r_result;
        w_nextState = (r_index == LAST_INDEX) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_index     <= '0;
      r_potential <= '0;
      r_result    <= '0;
      r_addA      <= '0;
      r_addB      <= '0;
      r_overrun   <= 1'b0;
      r_addErr    <= 1'b0;
    end else begin
      if (timestep_start && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (timestep_start) r_index <= '0;
        end
        ST_CALC: begin
          r_potential <= mem_rd_potential;
          r_result    <= w_direct;
          r_addA      <= w_halfVal;
          r_addB      <= w_quarterVal;
        end
        ST_ADDW: begin
          // An adder exception leaves the neuron undecayed rather than storing a bad sum.
          if (add_done) begin
            if (add_exception) begin
              r_result <= r_potential;
              r_addErr <= 1'b1;
            end else begin
              r_result <= add_result;
            end
          end
        end
        ST_WR: begin
          if (r_index != LAST_INDEX) r_index <= r_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decay_timestep_scheduler.sv
// Scoreboard bench: a behavioural decay model predicts every write-back and adder request,
// while a memory model, an adder stub and a write monitor check the sweeps independently.
module tb_decay_timestep_scheduler;
  import neuron_pkg::*;

  localparam int NUM    = 4;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              timestep_start;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              add_err;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_potential;
  logic [3:0]        mem_rd_rate;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              add_valid;
  logic              add_ready;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_done;
  logic [31:0]       add_result;
  logic              add_exception;

  always #5 clk = ~clk;

  decay_timestep_scheduler #(.NUM_NEURONS(NUM), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .timestep_start   (timestep_start),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun),
    .add_err          (add_err),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_potential (mem_rd_potential),
    .mem_rd_rate      (mem_rd_rate),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .add_valid        (add_valid),
    .add_ready        (add_ready),
    .add_a            (add_a),
    .add_b            (add_b),
    .add_done         (add_done),
    .add_result       (add_result),
    .add_exception    (add_exception)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    int          delay;
    logic [31:0] result;
    logic        exc;
  } add_t;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCnt = 0;
  int          doneCount = 0;
  logic [31:0] potMem [NUM];
  logic [3:0]  rateMem [NUM];
  int          planStall [NUM];
  int          planDelay [NUM];
  logic [31:0] planResult [NUM];
  logic        planExc [NUM];
  wr_t         expWrQ [$];
  add_t        addQ [$];
  logic        expErr;
  logic        expOverrun;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Decay expressed as scaling by 2^-k on the exponent value, with underflow to signed zero.
  function automatic logic [31:0] decayModel(input logic [31:0] v, input logic [3:0] rate);
    int e;
    int k;
    e = int'((v >> 23) & 32'hFF);
    if (e == 255) return v;
    case (rate)
      4'b0010: k = 1;
      4'b0100: k = 2;
      4'b1000: k = 3;
      default: return v;
    endcase
    if (e > k) return v - (32'(k) << 23);
    return v & 32'h8000_0000;
  endfunction

  function automatic logic [31:0] randValue();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return {1'($urandom), 8'($urandom_range(0, 4)), 23'($urandom)};
      2:       return {1'($urandom), 8'hFF, 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [3:0] randRate();
    case ($urandom_range(0, 5))
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      3:       return 4'b1000;
      4:       return 4'b0011;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic randomizePlan();
    for (int i = 0; i < NUM; i++) begin
      planStall[i]  = $urandom_range(0, 3);
      planDelay[i]  = $urandom_range(0, 3);
      planResult[i] = $urandom;
      planExc[i]    = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({busy, done, overrun, add_err, mem_rd_en, mem_wr_en, add_valid}), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, mem_wr_data, 32'd0);
    checkOutput({tag, "_add_a"}, add_a, 32'd0);
    checkOutput({tag, "_add_b"}, add_b, 32'd0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkZero("reset");
    rst = 1'b0;
    expErr     = 1'b0;
    expOverrun = 1'b0;
    expWrQ.delete();
    addQ.delete();
    @(negedge clk);
  endtask

  // mode 0: plain sweep; mode 1: extra start mid-sweep; mode 2: extra start in the done cycle.
  task automatic applyStimulus(input string tag, input int mode, input bit checkLatency);
    logic [31:0] v;
    logic [31:0] wrExp;
    add_t        t;
    wr_t         w;
    int          startCycle;
    int          waited;
    int          doneBefore;
    for (int i = 0; i < NUM; i++) begin
      v = potMem[i];
      if (((v >> 23) & 32'hFF) != 32'hFF && rateMem[i] == 4'b0011) begin
        t.a      = decayModel(v, 4'b0010);
        t.b      = decayModel(v, 4'b0100);
        t.stall  = planStall[i];
        t.delay  = planDelay[i];
        t.result = planResult[i];
        t.exc    = planExc[i];
        addQ.push_back(t);
        wrExp = planExc[i] ? v : planResult[i];
        if (planExc[i]) expErr = 1'b1;
      end else begin
        wrExp = decayModel(v, rateMem[i]);
      end
      w.addr = i;
      w.data = wrExp;
      expWrQ.push_back(w);
    end
    doneBefore     = doneCount;
    timestep_start = 1'b1;
    startCycle     = cycleCnt;
    @(negedge clk);
    timestep_start = 1'b0;
    if (mode == 1) begin
      repeat (4) @(negedge clk);
      timestep_start = 1'b1;
      expOverrun     = 1'b1;
      @(negedge clk);
      timestep_start = 1'b0;
    end
    waited = 0;
    while (!done && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: got no done, required done within 2000 cycles", tag);
    end else begin
      if (checkLatency) checkOutput({tag, "_latency"}, 32'(cycleCnt - startCycle), 32'(3 * NUM + 1));
      if (mode == 2) begin
        timestep_start = 1'b1;
        expOverrun     = 1'b1;
      end
    end
    @(negedge clk);
    timestep_start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_pulses"}, 32'(doneCount - doneBefore), 32'd1);
    checkOutput({tag, "_pending_writes"}, 32'(expWrQ.size()), 32'd0);
    checkOutput({tag, "_add_err"}, 32'(add_err), 32'(expErr));
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'(expOverrun));
  endtask

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  // Memory answers the cycle after a read strobe; at any other time it shows garbage.
  initial begin : memModel
    bit rdPrev;
    int rdAddrPrev;
    rdPrev           = 1'b0;
    rdAddrPrev       = 0;
    mem_rd_potential = '0;
    mem_rd_rate      = '0;
    forever begin
      @(negedge clk);
      if (rdPrev) begin
        mem_rd_potential = potMem[rdAddrPrev % NUM];
        mem_rd_rate      = rateMem[rdAddrPrev % NUM];
      end else begin
        mem_rd_potential = $urandom;
        mem_rd_rate      = 4'($urandom);
      end
      rdPrev     = mem_rd_en;
      rdAddrPrev = int'(mem_addr);
    end
  end

  initial begin : writeMonitor
    wr_t w;
    forever begin
      @(negedge clk);
      if (done) doneCount++;
      if (mem_wr_en) begin
        checkOutput("rd_wr_exclusive", 32'(mem_rd_en), 32'd0);
        if (expWrQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_write: got write addr %0d data 0x%08h, required none", mem_addr, mem_wr_data);
        end else begin
          w = expWrQ.pop_front();
          checkOutput($sformatf("wr_addr_%0d", w.addr), 32'(mem_addr), 32'(w.addr));
          checkOutput($sformatf("wr_data_%0d", w.addr), mem_wr_data, w.data);
        end
      end
    end
  end

  initial begin : adderStub
    add_t t;
    add_ready     = 1'b0;
    add_done      = 1'b0;
    add_result    = '0;
    add_exception = 1'b0;
    forever begin
      @(negedge clk);
      if (add_valid) begin
        if (addQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL add_unexpected: got adder request a=0x%08h b=0x%08h, required none", add_a, add_b);
          t.a      = add_a;
          t.b      = add_b;
          t.stall  = 0;
          t.delay  = 0;
          t.result = add_a;
          t.exc    = 1'b0;
        end else begin
          t = addQ.pop_front();
        end
        checkOutput("add_a", add_a, t.a);
        checkOutput("add_b", add_b, t.b);
        for (int s = 0; s < t.stall; s++) begin
          @(negedge clk);
          checkOutput("add_valid_held", 32'(add_valid), 32'd1);
          checkOutput("add_a_held", add_a, t.a);
          checkOutput("add_b_held", add_b, t.b);
        end
        add_ready = 1'b1;
        @(negedge clk);
        add_ready = 1'b0;
        checkOutput("add_valid_drop", 32'(add_valid), 32'd0);
        for (int d = 0; d < t.delay; d++) @(negedge clk);
        add_done      = 1'b1;
        add_result    = t.result;
        add_exception = t.exc;
        @(negedge clk);
        add_done      = 1'b0;
        add_exception = 1'b0;
        add_result    = $urandom;
      end
    end
  end

  initial begin : mainSeq
    int waited;
    int doneBefore;
    wr_t w;
    rst            = 1'b1;
    timestep_start = 1'b0;
    expErr         = 1'b0;
    expOverrun     = 1'b0;
    randomizePlan();
    @(negedge clk);
    applyReset();

    for (int i = 0; i < NUM; i++) begin
      potMem[i]  = 32'h41DE_D852;
      rateMem[i] = 4'b0010;
    end
    applyStimulus("div2_sweep", 0, 1'b1);

    potMem  = '{32'h41DE_D852, 32'h41DE_D852, 32'h41DE_D852, 32'h0080_0000};
    rateMem = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    applyStimulus("rate_codes", 0, 1'b1);

    potMem  = '{32'h8080_0000, 32'h7F80_0000, 32'h41DE_D852, 32'h7FC0_0000};
    rateMem = '{4'b0010, 4'b0010, 4'b0111, 4'b0011};
    applyStimulus("special_values", 0, 1'b1);

    potMem        = '{32'h41DE_D852, 32'h41DE_D852, 32'h41DE_D852, 32'h41DE_D852};
    rateMem       = '{4'b0011, 4'b0010, 4'b0100, 4'b1000};
    planStall[0]  = 2;
    planDelay[0]  = 1;
    planResult[0] = 32'h41A7_223C;
    planExc[0]    = 1'b0;
    applyStimulus("half_quarter", 0, 1'b0);

    planExc[0] = 1'b1;
    applyStimulus("half_quarter_exc", 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      randomizePlan();
      for (int i = 0; i < NUM; i++) begin
        potMem[i]  = randValue();
        rateMem[i] = randRate();
      end
      applyStimulus($sformatf("random_%0d", n), 0, 1'b0);
    end

    applyReset();
    for (int i = 0; i < NUM; i++) begin
      potMem[i]  = randValue();
      rateMem[i] = 4'b0010;
    end
    applyStimulus("overrun_mid", 1, 1'b1);

    applyReset();
    applyStimulus("start_at_done", 2, 1'b1);

    applyReset();
    for (int i = 0; i < NUM; i++) begin
      potMem[i]  = randValue();
      rateMem[i] = 4'b0010;
    end
    for (int i = 0; i < 2; i++) begin
      w.addr = i;
      w.data = decayModel(potMem[i], 4'b0010);
      expWrQ.push_back(w);
    end
    doneBefore     = doneCount;
    timestep_start = 1'b1;
    @(negedge clk);
    timestep_start = 1'b0;
    waited = 0;
    while (!(mem_wr_en && mem_addr == 12'd1) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!(mem_wr_en && mem_addr == 12'd1)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL mid_reset_wait: got no write to neuron 1, required one within 100 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    checkZero("mid_reset");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("mid_reset_no_done", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("mid_reset_pending", 32'(expWrQ.size()), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
